// File: rtl/alu_ctrl_pkg.sv
// alu_ctrl_pkg: shared state encoding, opcode constants and decode LUT for the ALU control sequencer.
// ALU_CTRL_MULTICYCLE_EN enables the iterating shift opcodes identified by is_multi().
package alu_ctrl_pkg;

    typedef enum logic [1:0] {IDLE, EXEC, ITER} alu_state_t;

    localparam logic [3:0] OP_NOP   = 4'h0;
    localparam logic [3:0] OP_SHL_N = 4'hE;
    localparam logic [3:0] OP_SHR_N = 4'hF;

    // Control word layout at the default width: {CS[1:0], LHS[1:0], RHS[3:0]}
    localparam logic [7:0] ALU_CTRL_LUT [16] = '{
        8'h00, 8'h09, 8'h4A, 8'h05, 8'h06, 8'h07, 8'h08, 8'h0B,
        8'h0C, 8'h0D, 8'h1A, 8'h2B, 8'h3C, 8'h4D, 8'h83, 8'hC3
    };

    function automatic logic is_multi(input logic [3:0] op);
        return op == OP_SHL_N || op == OP_SHR_N;
    endfunction

endpackage

// File: rtl/alu_ctrl_decode.sv
// alu_ctrl_decode: combinational opcode decode into control word, active and multi-cycle flags.
// Multi-cycle flag is only raised when ALU_CTRL_MULTICYCLE_EN is defined.
module alu_ctrl_decode
    import alu_ctrl_pkg::*;
#(
    parameter int OP_W   = 4,
    parameter int CTRL_W = 8
) (
    input  logic [OP_W-1:0]   op,
    output logic [CTRL_W-1:0] ctrl,
    output logic              active,
    output logic              multi
);

    logic [3:0] idx;
    logic       in_lut;

    // Opcodes beyond the 16-entry table decode to an all-zero word
    assign idx    = 4'(op);
    assign in_lut = (op >> 4) == '0;
    assign ctrl   = in_lut ? CTRL_W'(ALU_CTRL_LUT[idx]) : '0;
    assign active = op != OP_W'(OP_NOP);
`ifdef ALU_CTRL_MULTICYCLE_EN
    assign multi  = in_lut && is_multi(idx);
`else
    assign multi  = 1'b0;
`endif

endmodule

// File: rtl/alu_ctrl_seq.sv
// alu_ctrl_seq: registered ALU control sequencer with valid/ready intake, clock-enable and stall.
// ALU_CTRL_MULTICYCLE_EN builds the ITER state and iteration counter for shift-by-N opcodes.
module alu_ctrl_seq
    import alu_ctrl_pkg::*;
#(
    parameter int OP_W     = 4,
    parameter int CTRL_W   = 8,
    parameter int MAX_ITER = 8,
    parameter int CNT_W    = $clog2(MAX_ITER + 1)
) (
    input  logic              Clock,
    input  logic              Reset_n,
    input  logic              OpValid,
    output logic              OpReady,
    input  logic [OP_W-1:0]   OpCode,
    input  logic [CNT_W-1:0]  OpCount,
    input  logic              Stall,
    output logic [CTRL_W-1:0] AluCtrl,
    output logic              AluActive,
    output logic              AluEnable,
    output logic              Done
);

    alu_state_t        state;
    logic [CTRL_W-1:0] dec_ctrl;
    logic              dec_active;
    logic              dec_multi;
    logic              accept;
    logic              last;

    alu_ctrl_decode #(.OP_W(OP_W), .CTRL_W(CTRL_W)) u_decode (
        .op     (OpCode),
        .ctrl   (dec_ctrl),
        .active (dec_active),
        .multi  (dec_multi)
    );

`ifdef ALU_CTRL_MULTICYCLE_EN
    logic [CNT_W-1:0] rem;
    logic [CNT_W-1:0] load_cnt;

    assign load_cnt = (OpCount == '0) ? CNT_W'(1) :
                      (OpCount > CNT_W'(MAX_ITER)) ? CNT_W'(MAX_ITER) : OpCount;
    assign last     = state != ITER || rem == CNT_W'(1);

    always_ff @(posedge Clock) begin
        if (!Reset_n)
            rem <= '0;
        else if (!Stall)
            rem <= accept ? load_cnt : rem - CNT_W'(1);
    end
`else
    logic count_unused;

    assign count_unused = ^OpCount;
    assign last         = 1'b1;
`endif

    assign OpReady   = !Stall && last;
    assign accept    = OpValid && OpReady;
    assign AluActive = state != IDLE;
    // Reset gating keeps an aborted op from showing an enable or Done in its last cycle
    assign AluEnable = AluActive && !Stall && Reset_n;
    assign Done      = AluEnable && last;

    always_ff @(posedge Clock) begin
        if (!Reset_n) begin
            state   <= IDLE;
            AluCtrl <= '0;
        end else if (accept) begin
            AluCtrl <= dec_ctrl;
            state   <= !dec_active ? IDLE : dec_multi ? ITER : EXEC;
        end else if (!Stall && last) begin
            state   <= IDLE;
        end
    end

endmodule

// File: tb/tb_alu_ctrl_seq.sv
// tb_alu_ctrl_seq: directed self-checking bench for alu_ctrl_seq.
// Expectations follow ALU_CTRL_MULTICYCLE_EN when it is defined for the build.
module tb_alu_ctrl_seq;

    localparam int CNT_W = 4;

    logic             Clock   = 1'b0;
    logic             Reset_n = 1'b0;
    logic             OpValid = 1'b0;
    logic             Stall   = 1'b0;
    logic [3:0]       OpCode  = '0;
    logic [CNT_W-1:0] OpCount = '0;
    logic             OpReady, AluActive, AluEnable, Done;
    logic [7:0]       AluCtrl;

    int          vectors     = 0;
    int          miscompares = 0;
    int          act;
    logic [15:0] enm, rdym, dnm;

    always #5 Clock = ~Clock;

    alu_ctrl_seq dut (
        .Clock     (Clock),
        .Reset_n   (Reset_n),
        .OpValid   (OpValid),
        .OpReady   (OpReady),
        .OpCode    (OpCode),
        .OpCount   (OpCount),
        .Stall     (Stall),
        .AluCtrl   (AluCtrl),
        .AluActive (AluActive),
        .AluEnable (AluEnable),
        .Done      (Done)
    );

    task automatic tick();
        @(posedge Clock);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Accept one op, then record per-cycle enable/ready/done while it stays active
    task automatic issue(input logic [3:0] op, input logic [CNT_W-1:0] cnt,
                         input logic [15:0] smask, input logic [7:0] exp_ctrl);
        OpValid = 1'b1;
        OpCode  = op;
        OpCount = cnt;
        tick();
        OpValid = 1'b0;
        OpCount = '1;
        act  = 0;
        enm  = '0;
        rdym = '0;
        dnm  = '0;
        for (int i = 0; i < 40 && AluActive; i++) begin
            Stall = i < 16 && smask[i[3:0]];
            #1;
            if (i < 16) begin
                enm[i[3:0]]  = AluEnable;
                rdym[i[3:0]] = OpReady;
                dnm[i[3:0]]  = Done;
            end
            act++;
            chk("op_ctrl", AluCtrl, exp_ctrl);
            tick();
        end
        Stall = 1'b0;
    endtask

    initial begin
        tick();
        tick();
        Reset_n = 1'b1;
        #1;
        chk("rst_ctrl", AluCtrl, 8'h00);
        chk("rst_active", AluActive, 0);
        chk("rst_en", AluEnable, 0);
        chk("rst_done", Done, 0);
        chk("rst_ready", OpReady, 1);

        OpValid = 1'b1;
        OpCode  = 4'h1;
        tick();
        OpCode  = 4'h2;
        #1;
        chk("b2b_ctrl1", AluCtrl, 8'h09);
        chk("b2b_en1", AluEnable, 1);
        chk("b2b_done1", Done, 1);
        chk("b2b_ready1", OpReady, 1);
        tick();
        OpValid = 1'b0;
        #1;
        chk("b2b_ctrl2", AluCtrl, 8'h4A);
        chk("b2b_en2", AluEnable, 1);
        chk("b2b_done2", Done, 1);
        tick();
        #1;
        chk("idle_active", AluActive, 0);
        chk("idle_en", AluEnable, 0);
        chk("idle_ctrl_hold", AluCtrl, 8'h4A);

        OpValid = 1'b1;
        OpCode  = 4'h0;
        tick();
        OpValid = 1'b0;
        #1;
        chk("nop_ctrl", AluCtrl, 8'h00);
        chk("nop_active", AluActive, 0);
        chk("nop_en", AluEnable, 0);
        chk("nop_done", Done, 0);

        Stall   = 1'b1;
        OpValid = 1'b1;
        OpCode  = 4'h1;
        #1;
        chk("stall_ready", OpReady, 0);
        tick();
        Stall   = 1'b0;
        OpValid = 1'b0;
        #1;
        chk("stall_noacc_active", AluActive, 0);
        chk("stall_noacc_ctrl", AluCtrl, 8'h00);

`ifdef ALU_CTRL_MULTICYCLE_EN
        issue(4'hE, 4'd3, 16'h0000, 8'h83);
        chk("multi_act", act, 3);
        chk("multi_en", enm, 16'b111);
        chk("multi_ready", rdym, 16'b100);
        chk("multi_done", dnm, 16'b100);

        issue(4'hE, 4'd3, 16'b0110, 8'h83);
        chk("stall_act", act, 5);
        chk("stall_en", enm, 16'b11001);
        chk("stall_ready", rdym, 16'b10000);
        chk("stall_done", dnm, 16'b10000);

        issue(4'hF, 4'd0, 16'h0000, 8'hC3);
        chk("cnt0_en", enm, 16'b1);
        chk("cnt0_done", dnm, 16'b1);

        issue(4'hF, 4'd8, 16'h0000, 8'hC3);
        chk("cntmax_act", act, 8);
        chk("cntmax_en", enm, 16'hFF);
        chk("cntmax_done", dnm, 16'h80);

        issue(4'hF, 4'd15, 16'h0000, 8'hC3);
        chk("cntsat_act", act, 8);
`else
        issue(4'hE, 4'd3, 16'h0000, 8'h83);
        chk("single_act", act, 1);
        chk("single_en", enm, 16'b1);
        chk("single_done", dnm, 16'b1);

        issue(4'hE, 4'd3, 16'b0011, 8'h83);
        chk("stall_act", act, 3);
        chk("stall_en", enm, 16'b100);
        chk("stall_ready", rdym, 16'b100);
        chk("stall_done", dnm, 16'b100);

        issue(4'hF, 4'd5, 16'h0000, 8'hC3);
        chk("cnt5_act", act, 1);
        chk("cnt5_en", enm, 16'b1);
`endif

        OpValid = 1'b1;
        OpCode  = 4'hE;
        OpCount = 4'd5;
        tick();
        OpValid = 1'b0;
        Reset_n = 1'b0;
        #1;
        chk("abort_en", AluEnable, 0);
        chk("abort_done", Done, 0);
        tick();
        Reset_n = 1'b1;
        #1;
        chk("abort_ctrl", AluCtrl, 8'h00);
        chk("abort_active", AluActive, 0);
        chk("abort_ready", OpReady, 1);
        tick();
        #1;
        chk("abort_late_done", Done, 0);
        chk("abort_late_en", AluEnable, 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
